// File: rtl/dice_light_pkg.sv
// Shared definitions for the dice/traffic-light front end: debounce defaults,
// debounce FSM states and the downstream traffic-light result encodings.
package dice_light_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 4;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } dbnc_state_t;

  localparam logic [2:0] LIGHT_GREEN      = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW     = 3'b010;
  localparam logic [2:0] LIGHT_RED        = 3'b100;
  localparam logic [2:0] LIGHT_RED_YELLOW = 3'b110;

endpackage

// File: rtl/button_conditioner_debounce_ch.sv
// debounce_ch: one input channel -- 2-flop synchroniser, debounce counter/FSM,
// debounced level and a registered one-cycle rise strobe.
module debounce_ch
  import dice_light_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_rise_now
);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic             r_rise;
  logic [CNT_W-1:0] r_count;
  dbnc_state_t      r_state;

  logic             w_mismatch;
  logic             w_done;
  logic [CNT_W-1:0] w_count_inc;

  assign w_mismatch  = (r_s2 != r_stable);
  // The counter sits at 0 in STABLE, so the first mismatching edge counts as 1.
  assign w_count_inc = (r_state == STABLE) ? CNT_W'(1) : r_count + CNT_W'(1);
  assign w_done      = w_mismatch && (w_count_inc == CNT_W'(DEBOUNCE_CYCLES));
  assign o_rise_now  = w_done && r_s2;

  // NOTE: all state, synchroniser flops included, is reset asynchronously and
  // updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_count  <= '0;
      r_state  <= STABLE;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_rise <= o_rise_now;
      case (r_state)
        STABLE: begin
          r_count <= '0;
          if (w_done) begin
            r_stable <= r_s2;
          end else if (w_mismatch) begin
            r_count <= w_count_inc;
            r_state <= PENDING;
          end
        end
        PENDING: begin
          if (!w_mismatch || w_done) begin
            if (w_done) r_stable <= r_s2;
            r_count <= '0;
            r_state <= STABLE;
          end else begin
            r_count <= w_count_inc;
          end
        end
        default: begin
          r_count <= '0;
          r_state <= STABLE;
        end
      endcase
    end
  end

  assign o_level = r_stable;
  assign o_rise  = r_rise;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises and debounces raw button/sel inputs.
// Optional macro SEL_TOGGLE_EN turns sel into a push-to-toggle control.
module button_conditioner
  import dice_light_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_button,
  input  logic raw_sel,
  output logic button,
  output logic button_pulse,
  output logic sel
);

  logic w_btn_level;
  logic w_btn_rise;
  logic w_btn_rise_now;
  logic w_sel_level;
  logic w_sel_rise;
  logic w_sel_rise_now;

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn_ch (
    .clk       (clk),
    .rst       (rst),
    .i_raw     (raw_button),
    .o_level   (w_btn_level),
    .o_rise    (w_btn_rise),
    .o_rise_now(w_btn_rise_now)
  );

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_sel_ch (
    .clk       (clk),
    .rst       (rst),
    .i_raw     (raw_sel),
    .o_level   (w_sel_level),
    .o_rise    (w_sel_rise),
    .o_rise_now(w_sel_rise_now)
  );

  assign button       = w_btn_level;
  assign button_pulse = w_btn_rise;

`ifdef SEL_TOGGLE_EN
  logic r_sel;
  logic w_unused;

  // Toggle on the same edge the sel channel's stable value rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sel <= 1'b0;
    else if (w_sel_rise_now) r_sel <= ~r_sel;
  end

  assign sel      = r_sel;
  assign w_unused = &{1'b0, w_btn_rise_now, w_sel_level, w_sel_rise};
`else
  logic w_unused;

  assign sel      = w_sel_level;
  assign w_unused = &{1'b0, w_btn_rise_now, w_sel_rise, w_sel_rise_now};
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (default parameters,
// 10 ns clock); the sel toggle scenario is built when SEL_TOGGLE_EN is defined.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic raw_button;
  logic raw_sel;
  logic button;
  logic button_pulse;
  logic sel;

  int n_pass  = 0;
  int n_total = 0;

  button_conditioner dut (
    .clk         (clk),
    .rst         (rst),
    .raw_button  (raw_button),
    .raw_sel     (raw_sel),
    .button      (button),
    .button_pulse(button_pulse),
    .sel         (sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    raw_button = 1'b1;
    raw_sel    = 1'b1;
    #2;
    n_total++;
    if ({button, button_pulse, sel} !== 3'b000)
      $display("FAIL reset_async: got %b expected 000", {button, button_pulse, sel});
    else n_pass++;
    for (int i = 0; i < 4; i++) tick();
    n_total++;
    if ({button, button_pulse, sel} !== 3'b000)
      $display("FAIL reset_held: got %b expected 000", {button, button_pulse, sel});
    else n_pass++;
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_total++;
      if (button !== 1'b0) $display("FAIL reset_release_early e%0d: got %b expected 0", i, button);
      else n_pass++;
    end
    tick();
    n_total++;
    if ({button, button_pulse, sel} !== 3'b111)
      $display("FAIL reset_release_e6: got %b expected 111", {button, button_pulse, sel});
    else n_pass++;
    tick();
    n_total++;
    if ({button, button_pulse} !== 2'b10)
      $display("FAIL reset_release_e7: got %b expected 10", {button, button_pulse});
    else n_pass++;
    raw_button = 1'b0;
    raw_sel    = 1'b0;
    do_reset();
  endtask

  task automatic test_clean_press();
    int pulses = 0;
    raw_button = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      pulses += int'(button_pulse);
      n_total++;
      if (button !== 1'b0) $display("FAIL press_early e%0d: got %b expected 0", i, button);
      else n_pass++;
    end
    tick();
    n_total++;
    if ({button, button_pulse} !== 2'b11)
      $display("FAIL press_e6: got %b expected 11", {button, button_pulse});
    else n_pass++;
    tick();
    n_total++;
    if ({button, button_pulse} !== 2'b10)
      $display("FAIL press_e7: got %b expected 10", {button, button_pulse});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(button_pulse);
    end
    n_total++;
    if (pulses != 0) $display("FAIL press_extra_pulses: got %0d expected 0", pulses);
    else n_pass++;
    raw_button = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      pulses += int'(button_pulse);
      n_total++;
      if (button !== 1'b1) $display("FAIL release_early e%0d: got %b expected 1", i, button);
      else n_pass++;
    end
    for (int i = 6; i <= 10; i++) begin
      tick();
      pulses += int'(button_pulse);
      if (i == 6) begin
        n_total++;
        if (button !== 1'b0) $display("FAIL release_e6: got %b expected 0", button);
        else n_pass++;
      end
    end
    n_total++;
    if (pulses != 0) $display("FAIL release_pulses: got %0d expected 0", pulses);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int pulses = 0;
    int pulse_at = -1;
    logic [3:0] pattern = 4'b1010;
    for (int p = 3; p >= 0; p--) begin
      raw_button = pattern[p];
      for (int k = 0; k < 2; k++) begin
        tick();
        pulses += int'(button_pulse);
      end
    end
    raw_button = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (button_pulse === 1'b1) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
      end
    end
    n_total++;
    if (pulses != 1) $display("FAIL bounce_pulse_count: got %0d expected 1", pulses);
    else n_pass++;
    n_total++;
    if (pulse_at != 6) $display("FAIL bounce_pulse_edge: got %0d expected 6", pulse_at);
    else n_pass++;
    raw_button = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_glitch();
    int sel_high = 0;
    raw_sel = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    raw_sel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      sel_high += int'(sel);
    end
    n_total++;
    if (sel_high != 0) $display("FAIL glitch_sel: got %0d high cycles expected 0", sel_high);
    else n_pass++;
    n_total++;
    if (dut.u_sel_ch.r_count !== '0)
      $display("FAIL glitch_count: got %0d expected 0", dut.u_sel_ch.r_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid_pending();
    int pulses = 0;
    raw_button = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b0;
    #2;
    n_total++;
    if ({button, button_pulse, dut.u_btn_ch.r_count} !== {2'b00, 3'd0})
      $display("FAIL midreset_clear: got %b expected 00000",
               {button, button_pulse, dut.u_btn_ch.r_count});
    else n_pass++;
    tick();
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      pulses += int'(button_pulse);
      n_total++;
      if (button !== 1'b0) $display("FAIL midreset_early e%0d: got %b expected 0", i, button);
      else n_pass++;
    end
    n_total++;
    if (pulses != 0) $display("FAIL midreset_pulses: got %0d expected 0", pulses);
    else n_pass++;
    tick();
    n_total++;
    if ({button, button_pulse} !== 2'b11)
      $display("FAIL midreset_e6: got %b expected 11", {button, button_pulse});
    else n_pass++;
    raw_button = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

`ifdef SEL_TOGGLE_EN
  task automatic test_sel_toggle();
    do_reset();
    raw_sel    = 1'b1;
    raw_button = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_total++;
    if (sel !== 1'b0) $display("FAIL toggle1_early: got %b expected 0", sel);
    else n_pass++;
    tick();
    n_total++;
    if ({sel, button_pulse} !== 2'b11)
      $display("FAIL toggle1_e6: got %b expected 11", {sel, button_pulse});
    else n_pass++;
    for (int i = 0; i < 4; i++) tick();
    raw_sel    = 1'b0;
    raw_button = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_total++;
    if (sel !== 1'b1) $display("FAIL toggle1_release: got %b expected 1", sel);
    else n_pass++;
    raw_sel = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_total++;
    if (sel !== 1'b1) $display("FAIL toggle2_early: got %b expected 1", sel);
    else n_pass++;
    tick();
    n_total++;
    if (sel !== 1'b0) $display("FAIL toggle2_e6: got %b expected 0", sel);
    else n_pass++;
    raw_sel = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_total++;
    if (sel !== 1'b0) $display("FAIL toggle2_release: got %b expected 0", sel);
    else n_pass++;
  endtask
`else
  task automatic test_sel_level();
    raw_sel = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_total++;
    if (sel !== 1'b0) $display("FAIL sel_rise_early: got %b expected 0", sel);
    else n_pass++;
    tick();
    n_total++;
    if (sel !== 1'b1) $display("FAIL sel_rise_e6: got %b expected 1", sel);
    else n_pass++;
    raw_sel = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_total++;
    if (sel !== 1'b1) $display("FAIL sel_fall_early: got %b expected 1", sel);
    else n_pass++;
    tick();
    n_total++;
    if (sel !== 1'b0) $display("FAIL sel_fall_e6: got %b expected 0", sel);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_reset_mid_pending();
`ifdef SEL_TOGGLE_EN
    test_sel_toggle();
`else
    test_sel_level();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input conditioning stage directly upstream of `dice_light`. It takes the raw, asynchronous `button` and `sel` switch signals from the board, synchronises them into the `clk` domain and debounces them. It delivers clean `button` and `sel` levels, plus a single-cycle `button_pulse`, to the dice/traffic-light block.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronised input must differ from its stable value before the stable value updates; legal range 1..65535.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: counter width; derived, never overridden.

Ports:
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `raw_button` in 1: unsynchronised button input.
- `raw_sel` in 1: unsynchronised select input.
- `button` out 1: debounced button level; feeds `dice_light.button`.
- `button_pulse` out 1: one-cycle strobe on each debounced 0→1 of `button`.
- `sel` out 1: debounced select; feeds `dice_light.sel`.

## Operation
- Each raw input passes through a 2-flop synchroniser (`s1`, `s2`).
- Per channel, there is a 2-state debounce FSM:
  - STABLE: `s2 == stable`; the counter is held at 0.
  - PENDING: `s2 != stable`; the counter increments each edge.
- In PENDING, if the edge would make `count == DEBOUNCE_CYCLES`, then on that edge:
  - `stable <= s2`;
  - `count <= 0`;
  - the FSM returns to STABLE.
- Any edge with `s2 == stable` while in PENDING (a glitch) returns to STABLE and sets `count <= 0`. No output change occurs.
- `button` = stable value of the button channel.
- `button_pulse` is registered. It is 1 on exactly the edge where the button channel's stable value goes 0→1, and 0 on the next edge. The 1→0 transition produces no pulse.
- `sel` = stable value of the sel channel (see Configuration).
- The two channels are fully independent. Simultaneous transitions on both raw inputs resolve in the same cycle.
- Counter width rule: `count` never exceeds `DEBOUNCE_CYCLES`, so there is no wrap. `DEBOUNCE_CYCLES = 1` updates on the first mismatching edge.

## Timing
- All outputs, synchroniser flops, counters and FSMs reset to 0 (STABLE) immediately on `rst` low, independent of `clk`.
- Reset mid-PENDING discards the partial count.
- After `rst` deasserts, the first edge behaves as a normal edge. There is no extra dead cycle.
- Latency: let E1 be the first edge that samples a new raw value held steady. Then:
  - `s2` updates at E2;
  - the stable output updates at E(2+DEBOUNCE_CYCLES), i.e. E6 with the default;
  - `button_pulse` is high from E6 until E7.
- A raw pulse shorter than `DEBOUNCE_CYCLES` cycles (after synchronisation) never reaches the outputs.
- The minimum spacing between two `button_pulse` strobes is 2·`DEBOUNCE_CYCLES` cycles.

## Configuration
- Macro: `SEL_TOGGLE_EN`.
- Defined: `raw_sel` is treated as a momentary push-button. `sel` toggles on each debounced 0→1 of the sel channel. Debounced 1→0 has no effect. Reset value is 0 (dice mode).
- Undefined: `sel` equals the debounced sel level (slide-switch behaviour).
- `button`/`button_pulse` behaviour is identical in both builds.

## Structure
- Shared package `dice_light_pkg` holds:
  - the `DEBOUNCE_DEFAULT` constant (4 for simulation);
  - the `dbnc_state_t` enum {STABLE, PENDING};
  - the traffic-light result encodings used downstream (001, 010, 100, 110).
- One sub-module, `debounce_ch`, contains the synchroniser, counter, FSM and rise strobe for a single input. It is instantiated twice; the top adds only the optional sel toggle flop.

## Test plan
Default parameters, 10 ns clock.
- Reset: hold `rst` = 0 with `raw_button` = `raw_sel` = 1. `button`, `button_pulse` and `sel` stay 0. Release `rst` → `button` = 1 exactly 6 edges later, with `button_pulse` = 1 for 1 cycle.
- Clean press: `raw_button` 0→1 held 100 ns → `button` rises at E6. `button_pulse` is high for exactly one cycle. Releasing produces `button` = 0 after 6 edges with no pulse.
- Bounce: `raw_button` toggles 1,0,1,0 every 20 ns, then holds 1 → exactly one `button_pulse`, 6 edges after the final rise is first sampled.
- Glitch rejection: a 30 ns (3-cycle) high on `raw_sel` → `sel` stays 0 and the counter returns to 0.
- Reset mid-PENDING: `raw_button` rises, `rst` is pulsed low at E4 → no pulse. After release, `button` rises 6 edges later.
- `SEL_TOGGLE_EN` build: two clean `raw_sel` presses → `sel` 0→1 after the first, 1→0 after the second. Simultaneously pressing `raw_button` gives `button_pulse` on the same edge as the first `sel` change.
